// File: rtl/block_fetch_from_mem_if.sv
// ---------------------------------------------------------------------------
// block_fetch_from_mem_if
//   Bundles the request, memory-read and block-output signals of
//   block_fetch_from_mem.
//
//   Request : start, start_ready, offset, block_idx
//   Memory  : mem_rd_en, mem_addr, mem_rdata (rdata valid 1 cycle after rd_en)
//   Output  : out_valid, out_ready, out_data[BLK_H][BLK_W], busy
//
//   Modports:
//     slave  - the fetch block itself
//     master - the surrounding system (requester, memory, downstream stage)
// ---------------------------------------------------------------------------
interface block_fetch_from_mem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12,
   parameter int BLK_H  = 8,
   parameter int BLK_W  = 8
);
   logic                                    start;
   logic                                    start_ready;
   logic [ADDR_W-1:0]                       offset;
   logic [31:0]                             block_idx;
   logic                                    mem_rd_en;
   logic [ADDR_W-1:0]                       mem_addr;
   logic [DATA_W-1:0]                       mem_rdata;
   logic                                    out_valid;
   logic                                    out_ready;
   logic [BLK_H-1:0][BLK_W-1:0][DATA_W-1:0] out_data;
   logic                                    busy;

   modport slave (
      input  start, offset, block_idx, mem_rdata, out_ready,
      output start_ready, mem_rd_en, mem_addr, out_valid, out_data, busy
   );

   modport master (
      output start, offset, block_idx, mem_rdata, out_ready,
      input  start_ready, mem_rd_en, mem_addr, out_valid, out_data, busy
   );
endinterface

// File: rtl/block_fetch_from_mem.sv
// ---------------------------------------------------------------------------
// block_fetch_from_mem
//   Fetches one BLK_H x BLK_W pixel block from a synchronous-read memory,
//   one word per cycle, into a register array and offers it downstream
//   (DCT/quantiser) with a valid/ready handshake.
//
//   base    = offset + (block_idx mod MAX_BLOCK_NUM) * BLK_H*BLK_W
//   addr(k) = base + k, raster order, all arithmetic mod 2**ADDR_W.
//
//   Ports:
//     clock   - rising-edge clock
//     reset_n - asynchronous, active-low reset
//     bus     - block_fetch_from_mem_if.slave (request, memory, output)
//
//   Optional feature macro: BLOCK_FETCH_TRANSPOSE_EN
//     defined   : word k lands in out_data[col][row] (needs BLK_H == BLK_W)
//     undefined : word k lands in out_data[row][col]
// ---------------------------------------------------------------------------
module block_fetch_from_mem #(
   parameter int                DATA_W        = 32,
   parameter int                ADDR_W        = 12,
   parameter int                BLK_H         = 8,
   parameter int                BLK_W         = 8,
   parameter int                MAX_BLOCK_NUM = 32,
   parameter logic [DATA_W-1:0] RESET_VAL     = DATA_W'(1)
) (
   input logic                   clock,
   input logic                   reset_n,
   block_fetch_from_mem_if.slave bus
);

   localparam int          N        = BLK_H * BLK_W;
   localparam int          CNT_W    = (N > 1)     ? $clog2(N)     : 1;
   localparam int          ROW_W    = (BLK_H > 1) ? $clog2(BLK_H) : 1;
   localparam int          COL_W    = (BLK_W > 1) ? $clog2(BLK_W) : 1;
   localparam logic [31:0] IDX_MASK = 32'(MAX_BLOCK_NUM - 1);

   generate
      if (MAX_BLOCK_NUM < 1 || (MAX_BLOCK_NUM & (MAX_BLOCK_NUM - 1)) != 0) begin : g_bad_max
         $error("MAX_BLOCK_NUM must be a power of two");
      end
`ifdef BLOCK_FETCH_TRANSPOSE_EN
      if (BLK_H != BLK_W) begin : g_bad_transpose
         $error("transposed write requires BLK_H == BLK_W");
      end
`endif
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t                                  state_q, state_d;
   logic [ADDR_W-1:0]                       base_q;
   logic [ADDR_W-1:0]                       base_calc;
   logic [CNT_W-1:0]                        rd_cnt_q;
   logic                                    rd_en_q;
   logic [ROW_W-1:0]                        cap_row_q;
   logic [COL_W-1:0]                        cap_col_q;
   logic [BLK_H-1:0][BLK_W-1:0][DATA_W-1:0] out_data_q;

   logic                                    start_ready_c;
   logic                                    busy_c;
   logic                                    out_valid_c;
   logic                                    mem_rd_en_c;
   logic [ADDR_W-1:0]                       mem_addr_c;

   // The block index is reduced with a mask (modulus is a power of two);
   // the product is truncated to ADDR_W, which is exact modulo 2**ADDR_W.
   assign base_calc = bus.offset + ADDR_W'((bus.block_idx & IDX_MASK) * 32'(N));

   // -------------------------------------------------------------------------
   // Next-state and output decode
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d       = state_q;
      start_ready_c = 1'b0;
      busy_c        = 1'b1;
      out_valid_c   = 1'b0;
      mem_rd_en_c   = 1'b0;
      mem_addr_c    = '0;

      case (state_q)
         S_IDLE: begin
            start_ready_c = 1'b1;
            busy_c        = 1'b0;
            if (bus.start) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_rd_en_c = 1'b1;
            mem_addr_c  = base_q + ADDR_W'(rd_cnt_q);
            if (rd_cnt_q == CNT_W'(N - 1)) state_d = S_WAIT;
         end
         S_WAIT: begin
            // Last read is in flight; its data is captured this cycle.
            state_d = S_HOLD;
         end
         S_HOLD: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of process ordering.
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // -------------------------------------------------------------------------
   // Read issue and capture datapath
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base_q     <= '0;
         rd_cnt_q   <= '0;
         rd_en_q    <= 1'b0;
         cap_row_q  <= '0;
         cap_col_q  <= '0;
         // NOTE: the block array is deliberately reset: its contents are a
         // visible output with a defined reset value, not scratch storage.
         out_data_q <= {N{RESET_VAL}};
      end else begin
         // Clearing rd_en_q on reset is what discards an in-flight word.
         rd_en_q <= mem_rd_en_c;

         if (bus.start && start_ready_c) begin
            base_q    <= base_calc;
            rd_cnt_q  <= '0;
            cap_row_q <= '0;
            cap_col_q <= '0;
         end else if (mem_rd_en_c) begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
         end

         // Data for a read issued last cycle arrives now; the capture
         // position trails the read counter by exactly one word.
         if (rd_en_q) begin
`ifdef BLOCK_FETCH_TRANSPOSE_EN
            out_data_q[cap_col_q][cap_row_q] <= bus.mem_rdata;
`else
            out_data_q[cap_row_q][cap_col_q] <= bus.mem_rdata;
`endif
            if (cap_col_q == COL_W'(BLK_W - 1)) begin
               cap_col_q <= '0;
               cap_row_q <= (cap_row_q == ROW_W'(BLK_H - 1)) ? '0 : cap_row_q + ROW_W'(1);
            end else begin
               cap_col_q <= cap_col_q + COL_W'(1);
            end
         end
      end
   end

   assign bus.start_ready = start_ready_c;
   assign bus.busy        = busy_c;
   assign bus.out_valid   = out_valid_c;
   assign bus.mem_rd_en   = mem_rd_en_c;
   assign bus.mem_addr    = mem_addr_c;
   assign bus.out_data    = out_data_q;

endmodule

// File: tb/tb_block_fetch_from_mem.sv
// ---------------------------------------------------------------------------
// tb_block_fetch_from_mem
//   Scoreboard bench for block_fetch_from_mem. Expected blocks, read
//   addresses and timing windows are derived at request acceptance from the
//   address rule and a memory array; a monitor on the falling edge compares
//   what the design presents. Honours BLOCK_FETCH_TRANSPOSE_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_block_fetch_from_mem;

   localparam int DATA_W        = 32;
   localparam int ADDR_W        = 12;
   localparam int BLK_H         = 8;
   localparam int BLK_W         = 8;
   localparam int MAX_BLOCK_NUM = 32;
   localparam int N             = BLK_H * BLK_W;
   localparam int DEPTH         = 1 << ADDR_W;
   localparam int BUDGET        = 500;
`ifdef BLOCK_FETCH_TRANSPOSE_EN
   localparam bit TRANSPOSE = 1'b1;
`else
   localparam bit TRANSPOSE = 1'b0;
`endif

   typedef logic [BLK_H-1:0][BLK_W-1:0][DATA_W-1:0] blk_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   block_fetch_from_mem_if #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLK_H(BLK_H), .BLK_W(BLK_W)
   ) bus_if ();

   block_fetch_from_mem #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLK_H(BLK_H), .BLK_W(BLK_W),
      .MAX_BLOCK_NUM(MAX_BLOCK_NUM), .RESET_VAL(32'd1)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus_if)
   );

   // Synchronous-read memory model: data one cycle after the strobe.
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clock) if (bus_if.mem_rd_en) bus_if.mem_rdata <= mem[bus_if.mem_addr];

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   blk_t              exp_blk_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];
   int                acc_cyc_q[$];
   int                rd_lo = -1, rd_hi = -1, valid_due = -1;
   logic              prev_valid = 1'b0;
   blk_t              reset_blk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference block: word k of the block lives at (base + k) mod DEPTH and
   // belongs at row k / BLK_W, column k mod BLK_W (swapped when transposed).
   function automatic blk_t model_block(input int unsigned base);
      blk_t b;
      int   r, c;
      for (int k = 0; k < N; k++) begin
         r = k / BLK_W;
         c = k % BLK_W;
         if (TRANSPOSE) b[c][r] = mem[(base + k) % DEPTH];
         else           b[r][c] = mem[(base + k) % DEPTH];
      end
      return b;
   endfunction

   function automatic int unsigned model_base(input int unsigned off, input int unsigned idx);
      return (off + (idx % MAX_BLOCK_NUM) * N) % DEPTH;
   endfunction

   // -------------------------------------------------------------------------
   // Monitor / scoreboard
   // -------------------------------------------------------------------------
   initial forever begin
      @(negedge clock);
      if (!reset_n) begin
         exp_blk_q.delete();
         exp_addr_q.delete();
         rd_lo      = -1;
         rd_hi      = -1;
         valid_due  = -1;
         prev_valid = 1'b0;
      end else begin
         // Idle exactly when no block is outstanding.
         check("start_ready", bus_if.start_ready, exp_blk_q.size() == 0);
         check("busy",        bus_if.busy,        exp_blk_q.size() != 0);

         check("rd_en_window", bus_if.mem_rd_en, rd_lo >= 0 && cyc >= rd_lo && cyc <= rd_hi);
         if (bus_if.mem_rd_en) begin
            if (exp_addr_q.size() == 0) fail_now("mem_addr unexpected read");
            else check("mem_addr", bus_if.mem_addr, exp_addr_q.pop_front());
         end

         if (bus_if.out_valid && !prev_valid) check("out_valid_latency", cyc, valid_due);

         if (bus_if.out_valid) begin
            if (exp_blk_q.size() == 0) begin
               fail_now("out_valid with no block expected");
            end else begin
               n_checks++;
               if (bus_if.out_data !== exp_blk_q[0]) begin
                  n_fail++;
                  for (int r = 0; r < BLK_H; r++)
                     for (int c = 0; c < BLK_W; c++)
                        if (bus_if.out_data[r][c] !== exp_blk_q[0][r][c]) begin
                           $display("FAIL out_data[%0d][%0d]: got %0d, expected %0d (cycle %0d)",
                                    r, c, bus_if.out_data[r][c], exp_blk_q[0][r][c], cyc);
                           r = BLK_H;
                           break;
                        end
               end
               if (bus_if.out_ready) void'(exp_blk_q.pop_front());
            end
         end
         prev_valid = bus_if.out_valid;

         if (bus_if.start && bus_if.start_ready) begin
            int unsigned base;
            base = model_base(bus_if.offset, bus_if.block_idx);
            exp_blk_q.push_back(model_block(base));
            for (int k = 0; k < N; k++) exp_addr_q.push_back(ADDR_W'((base + k) % DEPTH));
            rd_lo     = cyc + 1;
            rd_hi     = cyc + N;
            valid_due = cyc + N + 2;
            acc_cyc_q.push_back(cyc);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers (called in the posedge+1 phase)
   // -------------------------------------------------------------------------
   task automatic issue_start(input logic [ADDR_W-1:0] off, input logic [31:0] idx);
      int t = 0;
      while (!bus_if.start_ready && t < BUDGET) begin
         @(posedge clock); #1;
         t++;
      end
      if (!bus_if.start_ready) fail_now("start_ready timeout");
      bus_if.offset    = off;
      bus_if.block_idx = idx;
      bus_if.start     = 1'b1;
      @(posedge clock); #1;
      bus_if.start     = 1'b0;
   endtask

   task automatic wait_valid();
      int t = 0;
      while (!bus_if.out_valid && t < BUDGET) begin
         @(posedge clock); #1;
         t++;
      end
      if (!bus_if.out_valid) fail_now("out_valid timeout");
   endtask

   task automatic wait_idle(input bit random_ready);
      int t = 0;
      do begin
         if (random_ready) bus_if.out_ready = 1'($urandom_range(0, 1));
         @(posedge clock); #1;
         t++;
      end while (!bus_if.start_ready && t < BUDGET);
      if (!bus_if.start_ready) fail_now("idle timeout");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"},   bus_if.out_valid,   1'b0);
      check({tag, "_mem_rd_en"},   bus_if.mem_rd_en,   1'b0);
      check({tag, "_start_ready"}, bus_if.start_ready, 1'b1);
      check({tag, "_busy"},        bus_if.busy,        1'b0);
      check({tag, "_mem_addr"},    bus_if.mem_addr,    '0);
      check({tag, "_out_data"},    bus_if.out_data == reset_blk, 1'b1);
   endtask

   // -------------------------------------------------------------------------
   // Test sequence
   // -------------------------------------------------------------------------
   initial begin
      blk_t snap;
      int   n_acc;

      for (int r = 0; r < BLK_H; r++)
         for (int c = 0; c < BLK_W; c++) reset_blk[r][c] = DATA_W'(1);
      for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'(a);

      bus_if.start     = 1'b0;
      bus_if.offset    = '0;
      bus_if.block_idx = '0;
      bus_if.out_ready = 1'b0;

      // Reset held low
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Basic fetch: block 3 at offset 0 -> words 192..255
      bus_if.out_ready = 1'b1;
      issue_start(ADDR_W'(0), 32'd3);
      wait_valid();
      check("basic_out_data_0_1", bus_if.out_data[0][1], TRANSPOSE ? 200 : 193);
      check("basic_out_data_7_7", bus_if.out_data[BLK_H-1][BLK_W-1], 255);
      wait_idle(1'b0);

      // Reset during read k=20 of block 5 (base 320)
      issue_start(ADDR_W'(0), 32'd5);
      begin
         int t = 0;
         while (!(bus_if.mem_rd_en && bus_if.mem_addr == ADDR_W'(340)) && t < BUDGET) begin
            @(posedge clock); #1;
            t++;
         end
         if (t >= BUDGET) fail_now("read k=20 not seen");
      end
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midfetch_reset");
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      check_reset_outputs("after_reset");

      // Wrap: block 35 (mod 32 = 3), offset 4000 -> addresses 96..159
      issue_start(ADDR_W'(4000), 32'd35);
      wait_valid();
      check("wrap_out_data_0_0", bus_if.out_data[0][0], 96);
      check("wrap_out_data_7_7", bus_if.out_data[BLK_H-1][BLK_W-1], 159);
      wait_idle(1'b0);

      // Backpressure: 10 cycles of out_ready=0, stray start during HOLD
      bus_if.out_ready = 1'b0;
      issue_start(ADDR_W'(17), 32'd9);
      wait_valid();
      snap = bus_if.out_data;
      for (int i = 0; i < 10; i++) begin
         bus_if.start     = (i == 4);
         bus_if.offset    = ADDR_W'(1000);
         bus_if.block_idx = 32'd7;
         @(posedge clock); #1;
      end
      bus_if.start = 1'b0;
      check("hold_out_valid", bus_if.out_valid, 1'b1);
      check("hold_stable", bus_if.out_data == snap, 1'b1);
      bus_if.out_ready = 1'b1;
      @(posedge clock); #1;
      check("post_handshake_ready", bus_if.start_ready, 1'b1);
      n_acc = acc_cyc_q.size();
      issue_start(ADDR_W'(0), 32'd0);
      check("post_handshake_accept", acc_cyc_q.size(), n_acc + 1);
      wait_idle(1'b0);

      // Back-to-back: blocks 0 then 1, second reads 64..127
      issue_start(ADDR_W'(0), 32'd0);
      issue_start(ADDR_W'(0), 32'd1);
      wait_idle(1'b0);
      n_acc = acc_cyc_q.size();
      if (n_acc >= 2) check("b2b_accept_gap", acc_cyc_q[n_acc-1] - acc_cyc_q[n_acc-2], N + 3);
      else            fail_now("b2b_accept_count");

      // Randomised blocks with random memory and random backpressure
      for (int it = 0; it < 6; it++) begin
         for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
         bus_if.out_ready = 1'($urandom_range(0, 1));
         issue_start(ADDR_W'($urandom), $urandom);
         wait_idle(1'b1);
      end

      repeat (3) @(posedge clock);
      #1;
      check("scoreboard_drained", exp_blk_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/block_fetch_from_mem.md
Name: block_fetch_from_mem

Overview:
- Parametrised successor to the combinational 8x8 block-from-memory extractor.
- Fetches one BLK_H x BLK_W pixel block from an external synchronous-read memory, one word per cycle, into an internal register array.
- Presents the filled block to the downstream DCT/quantiser stage with a valid/ready handshake.
- Sits between the frame/slice memory and the transform pipeline of the ProRes encoder.

Parameters:
- DATA_W, 32, pixel/word width in bits.
- ADDR_W, 12, memory word-address width; memory depth 2**ADDR_W.
- BLK_H, 8, block rows.
- BLK_W, 8, block columns; N = BLK_H*BLK_W words per block.
- MAX_BLOCK_NUM, 32, block-index wrap modulus; must be a power of two.
- RESET_VAL, 1, reset value of every out_data element.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  fetch request.
- start_ready  out  1  high only in IDLE; a request is accepted when start && start_ready.
- offset  in  ADDR_W  base word address, sampled at accept.
- block_idx  in  32  block index, sampled at accept.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  block available.
- out_ready  in  1  downstream accepts the block.
- out_data  out  [BLK_H][BLK_W] x DATA_W  block array.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; start_ready=1; busy=0; out_valid=0; mem_rd_en=0; mem_addr=0.
  - Every out_data element = RESET_VAL.
  - Read counter and capture counter = 0.
  - Reset mid-fetch or mid-hold abandons the block; in-flight mem_rdata is discarded.
- Address rule:
  - base = offset + (block_idx mod MAX_BLOCK_NUM)*N.
  - addr(k) = base + k, for k = 0..N-1 in raster order (row = k / BLK_W, col = k mod BLK_W).
  - All arithmetic truncated to ADDR_W bits; wrap past 2**ADDR_W-1 to 0 is legal.
- FSM IDLE -> FETCH -> WAIT -> HOLD -> IDLE:
  - IDLE: on start && start_ready, latch base and go to FETCH. start while not in IDLE is ignored (no queueing).
  - FETCH: mem_rd_en=1 and mem_addr=addr(k) for k=0..N-1 on consecutive cycles, no bubbles. After issuing k=N-1, go to WAIT.
  - Every cycle after a read, mem_rdata is written into out_data[row][col] of that read's k, both in FETCH and in WAIT.
  - WAIT: mem_rd_en=0; captures the final word; go to HOLD.
  - HOLD: out_valid=1; out_data stable. On out_valid && out_ready, go to IDLE at that edge and clear out_valid.
- Latency:
  - start accepted in cycle 0 -> mem_rd_en high in cycles 1..N.
  - mem_rdata consumed in cycles 2..N+1.
  - out_valid first high in cycle N+2 (cycle 66 for 8x8).
- Throughput: a new start is accepted no earlier than the cycle after the out handshake, i.e. N+3 cycles per block minimum.
- out_data is updated progressively while not in HOLD. It is valid only while out_valid=1, and it holds its last value in IDLE.
- out_ready while not in HOLD is ignored.

Optional Feature:
- Macro: BLOCK_FETCH_TRANSPOSE_EN.
- When defined: word k is written to out_data[col][row], a transposed block for column-first DCT. Requires BLK_H == BLK_W; elaboration error otherwise.
- When undefined: raster write to out_data[row][col] as above.
- Addresses, timing and handshake are identical in both builds.

Test Plan:
- Reset: hold reset_n=0 -> all out_data = 1, out_valid=0, mem_rd_en=0, start_ready=1. Then assert reset_n=0 at read k=20 of a fetch -> same values, FSM in IDLE next cycle.
- Basic fetch: memory word a = a; offset=0, block_idx=3 -> mem_addr 192..255 in cycles 1..64; out_valid in cycle 66; out_data[r][c] = 192+8r+c.
- Wrap: block_idx=35 (mod 32 = 3), offset=4000 -> addresses (4192+k) mod 4096 = 96..159; out_data[0][0]=96, out_data[7][7]=159.
- Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid held and out_data stable. A start pulse during HOLD is ignored (no mem_rd_en). out_ready=1 -> IDLE, and a start in the next cycle is accepted.
- Back-to-back: block_idx 0 then 1 with out_ready=1 -> second fetch reads addresses 64..127, gap of exactly N+3 cycles between accepts.
- TRANSPOSE_EN build: basic-fetch stimulus -> out_data[c][r] = 192+8r+c, e.g. out_data[0][1]=200.
